// File: rtl/ysyx_25020047_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25020047_pkg
// Shared definitions for the ysyx_25020047 RV32E core front end:
//   - XLEN / ILEN     : datapath and instruction widths
//   - RESET_PC        : architectural PC after reset
//   - ifu_state_e     : 2-bit IFU fetch state encoding
//   - pc_next_seq()   : sequential PC step (wraps modulo 2^XLEN)
// ---------------------------------------------------------------------------
package ysyx_25020047_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  // Sequential fetch address; the carry out of bit XLEN-1 is dropped so
  // 0xFFFF_FFFC steps to 0x0000_0000.
  function automatic logic [XLEN-1:0] pc_next_seq(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_25020047_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_25020047_ifu
// Instruction fetch unit: holds the architectural PC, issues one fetch at a
// time over a valid/ready memory port and presents the returned word to the
// IDU over a valid/ready handshake. EXU redirects (jalr, pc_wen) override the
// sequential pc+4 step in every state.
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr        fetch request channel
//   imem_rsp_valid, imem_rsp_data          fetch response (one pulse/request)
//   inst_valid/ready, inst, inst_pc        instruction to the IDU
//   redirect_valid, redirect_pc            PC write from the EXU
//   perf_fetch_cnt                         IDU handshake counter
//
// Configuration
//   IFU_PERF_CNT_EN  when defined, perf_fetch_cnt exists and counts every
//                    inst_valid && inst_ready handshake (wraps at 2^32).
// ---------------------------------------------------------------------------
module ysyx_25020047_ifu
  import ysyx_25020047_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt
`endif
);

  ifu_state_e      r_state;
  ifu_state_e      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  // Set when the outstanding response belongs to a fetch made obsolete by a
  // redirect; that response must be swallowed, never shown to the IDU.
  logic            r_drop;
  logic            w_drop_nxt;
  logic            w_latch;
  logic [ILEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IFU_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, next-PC and drop-flag logic; redirect beats pc+4 everywhere.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop;
    w_latch     = 1'b0;
    case (r_state)
      IFU_IDLE: begin
        w_state_nxt = IFU_REQ;
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      IFU_REQ: begin
        if (imem_req_ready) begin
          w_state_nxt = IFU_WAIT;
          // Request already left with the old PC: its response is stale.
          if (redirect_valid) begin
            w_pc_nxt   = redirect_pc;
            w_drop_nxt = 1'b1;
          end else begin
            w_drop_nxt = 1'b0;
          end
        end else begin
          if (redirect_valid) begin
            w_pc_nxt = redirect_pc;
          end else begin
            w_pc_nxt = r_pc;
          end
        end
      end
      IFU_WAIT: begin
        if (imem_rsp_valid) begin
          if (r_drop || redirect_valid) begin
            w_state_nxt = IFU_REQ;
            w_drop_nxt  = 1'b0;
          end else begin
            w_state_nxt = IFU_HOLD;
            w_latch     = 1'b1;
          end
          if (redirect_valid) begin
            w_pc_nxt = redirect_pc;
          end else begin
            w_pc_nxt = r_pc;
          end
        end else begin
          if (redirect_valid) begin
            w_pc_nxt   = redirect_pc;
            w_drop_nxt = 1'b1;
          end else begin
            w_pc_nxt = r_pc;
          end
        end
      end
      IFU_HOLD: begin
        if (redirect_valid) begin
          // Held word either transfers this edge or is discarded; both leave.
          w_state_nxt = IFU_REQ;
          w_pc_nxt    = redirect_pc;
        end else if (inst_ready) begin
          w_state_nxt = IFU_REQ;
          w_pc_nxt    = pc_next_seq(r_pc);
        end else begin
          w_state_nxt = IFU_HOLD;
        end
      end
      default: begin
        w_state_nxt = IFU_IDLE;
        w_pc_nxt    = PC_RESET;
        w_drop_nxt  = 1'b0;
      end
    endcase
  end

  // Output decode: handshake valids depend on the state register only.
  always_comb begin
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    case (r_state)
      IFU_REQ: begin
        imem_req_valid = 1'b1;
        inst_valid     = 1'b0;
      end
      IFU_HOLD: begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b1;
      end
      default: begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
      end
    endcase
  end

  // PC and drop-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= PC_RESET;
      r_drop <= 1'b0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_drop <= w_drop_nxt;
    end
  end

  // Instruction output latch, loaded only by a live (non-dropped) response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst    <= 32'h0;
      r_inst_pc <= 32'h0;
    end else if (w_latch) begin
      r_inst    <= imem_rsp_data;
      r_inst_pc <= r_pc;
    end else begin
      r_inst    <= r_inst;
      r_inst_pc <= r_inst_pc;
    end
  end

  assign imem_addr = r_pc;
  assign inst      = r_inst;
  assign inst_pc   = r_inst_pc;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_perf_cnt;

  // Handshake counter; dropped fetches never reach HOLD so are never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cnt <= 32'h0;
    end else if ((r_state == IFU_HOLD) && inst_ready) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end else begin
      r_perf_cnt <= r_perf_cnt;
    end
  end

  assign perf_fetch_cnt = r_perf_cnt;
`endif

endmodule
